// File: rtl/demux1to4_8bit.sv
// Registered 1-to-4 byte demultiplexer with per-channel valid/ready holding registers and delivery counters.
// Define DEMUX_RR_EN to add the rr_mode port and round-robin channel steering.
module demux1to4_8bit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] D,
   input  logic       S1,
   input  logic       S0,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] Y0,
   output logic [7:0] Y1,
   output logic [7:0] Y2,
   output logic [7:0] Y3,
   output logic [3:0] out_valid,
   input  logic [3:0] out_ready,
`ifdef DEMUX_RR_EN
   input  logic       rr_mode,
`endif
   output logic [7:0] cnt0,
   output logic [7:0] cnt1,
   output logic [7:0] cnt2,
   output logic [7:0] cnt3
);

   logic [7:0] y_q   [4];
   logic [7:0] cnt_q [4];
   logic [3:0] vld_q;
   logic [3:0] drain;
   logic [1:0] sel;
   logic       accept;

`ifdef DEMUX_RR_EN
   logic [1:0] ptr;

   always_comb sel = rr_mode ? ptr : {S1, S0};

   // Pointer only advances on accepts made in round-robin mode; it survives mode changes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (accept && rr_mode) begin
         ptr <= ptr + 2'd1;
      end
   end
`else
   always_comb sel = {S1, S0};
`endif

   // Only the selected channel gates the input, so a full channel stalls the source.
   always_comb begin
      in_ready = rst_n && (!vld_q[sel] || out_ready[sel]);
      accept   = in_valid && in_ready;
      drain    = vld_q & out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int unsigned k = 0; k < 4; k++) begin
            y_q[k]   <= '0;
            cnt_q[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < 4; k++) begin
            if (drain[k]) begin
               vld_q[k] <= 1'b0;
               cnt_q[k] <= cnt_q[k] + 8'd1;
            end
         end
         // A same-edge fill overrides the drain's valid clear on the selected channel.
         if (accept) begin
            y_q[sel]   <= D;
            vld_q[sel] <= 1'b1;
         end
      end
   end

   always_comb begin
      Y0        = y_q[0];
      Y1        = y_q[1];
      Y2        = y_q[2];
      Y3        = y_q[3];
      cnt0      = cnt_q[0];
      cnt1      = cnt_q[1];
      cnt2      = cnt_q[2];
      cnt3      = cnt_q[3];
      out_valid = vld_q;
   end

endmodule

// File: tb/tb_demux1to4_8bit.sv
// Scoreboard bench for demux1to4_8bit: per-channel queues of expected bytes, checked by a negedge monitor.
module tb_demux1to4_8bit;

   typedef logic [7:0] bq_t [$];

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] D;
   logic       S1, S0;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] Y0, Y1, Y2, Y3;
   logic [3:0] out_valid;
   logic [3:0] out_ready;
   logic [7:0] cnt0, cnt1, cnt2, cnt3;
`ifdef DEMUX_RR_EN
   logic       rr_mode;
`endif

   logic [7:0] y [4];
   logic [7:0] c [4];
   assign y[0] = Y0;
   assign y[1] = Y1;
   assign y[2] = Y2;
   assign y[3] = Y3;
   assign c[0] = cnt0;
   assign c[1] = cnt1;
   assign c[2] = cnt2;
   assign c[3] = cnt3;

   // Reference model: bytes waiting in each channel, last delivered byte, delivered count, rr pointer.
   bq_t        q    [4];
   logic [7:0] hold [4];
   logic [7:0] mcnt [4];
   logic [1:0] mptr;
   bit         mrr;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   demux1to4_8bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .D         (D),
      .S1        (S1),
      .S0        (S0),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Y0        (Y0),
      .Y1        (Y1),
      .Y2        (Y2),
      .Y3        (Y3),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef DEMUX_RR_EN
      .rr_mode   (rr_mode),
`endif
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %02h, want %02h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] cur_sel();
      return mrr ? mptr : {S1, S0};
   endfunction

   task automatic flush();
      for (int k = 0; k < 4; k++) begin
         q[k].delete();
         hold[k] = 8'h00;
         mcnt[k] = 8'h00;
      end
      mptr = 2'd0;
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_Y%0d", tag, k), y[k], 8'h00);
         chk($sformatf("%s_cnt%0d", tag, k), c[k], 8'h00);
      end
      chk({tag, "_out_valid"}, {4'd0, out_valid}, 8'h00);
      chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'h00);
   endtask

   // Monitor: compares DUT state against the model, then retires bytes whose handshake completes next edge.
   always @(negedge clk) begin
      logic [1:0] s;
      if (!rst_n) begin
         chk("in_ready_in_reset", {7'd0, in_ready}, 8'h00);
         chk("out_valid_in_reset", {4'd0, out_valid}, 8'h00);
      end else begin
         s = cur_sel();
         chk("in_ready", {7'd0, in_ready}, 8'((q[s].size() == 0) || out_ready[s]));
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid%0d", k), {7'd0, out_valid[k]}, 8'(q[k].size() != 0));
            chk($sformatf("Y%0d", k), y[k], (q[k].size() != 0) ? q[k][0] : hold[k]);
            chk($sformatf("cnt%0d", k), c[k], mcnt[k]);
            if (out_ready[k] && q[k].size() != 0) begin
               hold[k] = q[k].pop_front();
               mcnt[k] = mcnt[k] + 8'd1;
            end
         end
      end
   end

   // Driver: presents one cycle of stimulus and pushes the byte if the model says it will be accepted.
   task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] s, input logic [3:0] rdy);
      logic [1:0] ms;
      @(posedge clk);
      #1;
      in_valid  = v;
      D         = d;
      {S1, S0}  = s;
      out_ready = rdy;
      @(negedge clk);
      #1;
      ms = cur_sel();
      if (rst_n && v && q[ms].size() == 0) begin
         q[ms].push_back(d);
         if (mrr) mptr = mptr + 2'd1;
      end
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      out_ready = 4'b0000;
   endtask

   initial begin
      logic [7:0] last;
      rst_n     = 1'b0;
      D         = 8'h00;
      S1        = 1'b0;
      S0        = 1'b0;
      mrr       = 1'b0;
      idle_inputs();
`ifdef DEMUX_RR_EN
      rr_mode   = 1'b0;
`endif
      flush();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;

      // Fill all four channels with no consumer ready, then every select must stall.
      cyc(1'b1, 8'h55, 2'd0, 4'b0000);
      cyc(1'b1, 8'h0F, 2'd1, 4'b0000);
      cyc(1'b1, 8'hF0, 2'd2, 4'b0000);
      cyc(1'b1, 8'h7F, 2'd3, 4'b0000);
      for (int s = 0; s < 4; s++) cyc(1'b1, 8'hAA, 2'(s), 4'b0000);
      chk("fill_out_valid", {4'd0, out_valid}, 8'h0F);
      chk("fill_Y0", Y0, 8'h55);
      chk("fill_Y1", Y1, 8'h0F);
      chk("fill_Y2", Y2, 8'hF0);
      chk("fill_Y3", Y3, 8'h7F);
      chk("fill_cnt0", cnt0, 8'h00);

      // Backpressure on channel 2, then release it for a simultaneous drain and fill.
      repeat (3) cyc(1'b1, 8'hC3, 2'd2, 4'b0000);
      cyc(1'b1, 8'hC3, 2'd2, 4'b0100);
      cyc(1'b0, 8'h00, 2'd0, 4'b0000);
      chk("bp_out_valid2", {7'd0, out_valid[2]}, 8'h01);
      chk("bp_Y2", Y2, 8'hC3);
      chk("bp_cnt2", cnt2, 8'h01);

      // 256 back-to-back bytes into channel 1 with its consumer always ready.
      last = 8'h00;
      for (int i = 0; i < 256; i++) begin
         last = 8'($urandom);
         cyc(1'b1, last, 2'd1, 4'b0010);
      end
      cyc(1'b0, 8'h00, 2'd0, 4'b0000);
      chk("stream_cnt1_wrap", cnt1, 8'h00);
      chk("stream_Y1_last", Y1, last);
      chk("stream_out_valid1", {7'd0, out_valid[1]}, 8'h01);

      // Asynchronous reset between edges with every channel full.
      #2;
      rst_n = 1'b0;
      flush();
      #1;
      chk_zero("async_reset");
      cyc(1'b1, 8'h11, 2'd0, 4'b1111);
      cyc(1'b1, 8'h22, 2'd1, 4'b1111);
      idle_inputs();
      #1;
      rst_n = 1'b1;

      // Refill, then drain channels 1 and 3 only.
      cyc(1'b1, 8'hA0, 2'd0, 4'b0000);
      cyc(1'b1, 8'hA1, 2'd1, 4'b0000);
      cyc(1'b1, 8'hA2, 2'd2, 4'b0000);
      cyc(1'b1, 8'hA3, 2'd3, 4'b0000);
      cyc(1'b0, 8'h00, 2'd0, 4'b1010);
      cyc(1'b0, 8'h00, 2'd0, 4'b0000);
      chk("indep_out_valid", {4'd0, out_valid}, 8'h05);
      chk("indep_cnt0", cnt0, 8'h00);
      chk("indep_cnt1", cnt1, 8'h01);
      chk("indep_cnt2", cnt2, 8'h00);
      chk("indep_cnt3", cnt3, 8'h01);

      // Random traffic against the scoreboard.
      repeat (400) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom), 4'($urandom));
      end

`ifdef DEMUX_RR_EN
      idle_inputs();
      cyc(1'b0, 8'h00, 2'd0, 4'b1111);
      #1;
      rst_n = 1'b0;
      flush();
      #2;
      idle_inputs();
      rst_n = 1'b1;
      rr_mode = 1'b1;
      mrr     = 1'b1;
      for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(i), 2'd3, 4'b1111);
      cyc(1'b0, 8'h00, 2'd3, 4'b1111);
      cyc(1'b0, 8'h00, 2'd3, 4'b1111);
      chk("rr_cnt0", cnt0, 8'h02);
      chk("rr_cnt1", cnt1, 8'h01);
      chk("rr_cnt3", cnt3, 8'h01);
      chk("rr_Y0", Y0, 8'h05);
      chk("rr_Y1", Y1, 8'h02);
      chk("rr_Y3", Y3, 8'h04);
      // With the pointer at 1, the next round-robin byte must land in Y1.
      cyc(1'b1, 8'h66, 2'd0, 4'b0000);
      cyc(1'b0, 8'h00, 2'd0, 4'b0000);
      chk("rr_ptr_Y1", Y1, 8'h66);
      chk("rr_ptr_out_valid", {4'd0, out_valid}, 8'h02);
      rr_mode = 1'b0;
      mrr     = 1'b0;
`endif

      cyc(1'b0, 8'h00, 2'd0, 4'b0000);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
